rs_issue_ctrl: RTL

- Issue scheduler between the instruction queue and the reservation stations of the Tomasulo-style core.
- Each cycle it decodes the instruction word presented by the queue and allocates a free slot in the adder RS (ADD/SUB) or the memory buffer (LD/SD).
- It renames sources through an internal register status table (RST) and asserts stall back to the queue when no slot is free.
- It releases slots and RST entries on common data bus (CDB) broadcasts.

---
 rtl/rs_issue_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rs_issue_ctrl.sv
// rs_issue_ctrl: issue scheduler for the Tomasulo-style core.
// Decodes the word offered by the instruction queue, allocates the lowest
// free adder reservation station (ADD/SUB) or memory buffer (LD/SD), and
// renames sources through an 8-entry register status table (RST).
// Stations and RST entries are released on common data bus broadcasts.
// Tags: 0 = ready, 1..ADD_RS = adder stations, ADD_RS+1..ADD_RS+MEM_RS = memory buffers.
// Optional macro ISSUE_STATS_EN adds saturating issue/stall counters on
// stat_issued / stat_stalls. Without it those ports are tied to zero.
module rs_issue_ctrl #(
   parameter int ADD_RS = 3,
   parameter int MEM_RS = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [2:0]        opcode,
   input  logic [2:0]        RX,
   input  logic [2:0]        RY,
   input  logic [2:0]        RZ,
   input  logic [3:0]        immediate,
   input  logic              cdb_valid,
   input  logic [2:0]        cdb_tag,
   output logic              stall,
   output logic              issue_valid,
   output logic              issue_unit,
   output logic [2:0]        issue_tag,
   output logic [2:0]        issue_op,
   output logic [2:0]        issue_qj,
   output logic [2:0]        issue_qk,
   output logic [2:0]        issue_rj,
   output logic [2:0]        issue_rk,
   output logic [3:0]        issue_imm,
   output logic [ADD_RS-1:0] add_busy,
   output logic [MEM_RS-1:0] mem_busy,
   output logic [15:0]       stat_issued,
   output logic [15:0]       stat_stalls
);

   localparam int NSLOT = ADD_RS + MEM_RS;

   // Occupancy and rename state
   logic [ADD_RS-1:0] add_busy_q, add_busy_d;
   logic [MEM_RS-1:0] mem_busy_q, mem_busy_d;
   logic [2:0]        rst_q [8];
   logic [2:0]        rst_d [8];

   // Decode results
   logic       need_alloc;
   logic       is_mem;
   logic       is_ld;
   logic       is_sd;
   logic       unit_full;
   logic       stall_c;
   logic       do_issue;
   logic       writes_dest;
   logic [2:0] add_sel_tag;
   logic [2:0] mem_sel_tag;
   logic [2:0] alloc_tag;
   logic [2:0] src_k;
   logic [2:0] qj_c;
   logic [2:0] qk_c;
   logic [2:0] rk_c;
   logic       cdb_hit;

   // A producer tag that completes on the CDB this cycle is already ready.
   function automatic logic [2:0] bypass(input logic [2:0] producer,
                                         input logic       bus_valid,
                                         input logic [2:0] bus_tag);
      if (bus_valid && (bus_tag == producer))
         return 3'd0;
      return producer;
   endfunction

   // Decode the offered word and decide between stall and issue
   always_comb begin
      need_alloc  = instr_valid & ~opcode[2];
      is_mem      = (opcode == 3'b010) || (opcode == 3'b011);
      is_ld       = (opcode == 3'b010);
      is_sd       = (opcode == 3'b011);
      unit_full   = is_mem ? (&mem_busy_q) : (&add_busy_q);
      stall_c     = need_alloc & unit_full;
      do_issue    = need_alloc & ~unit_full;
      writes_dest = do_issue & ~is_sd;
      cdb_hit     = cdb_valid && (cdb_tag != 3'd0) && (cdb_tag <= 3'(NSLOT));
   end

   // Lowest-index free slot of each unit (the downward scan leaves the lowest)
   always_comb begin
      add_sel_tag = 3'd0;
      mem_sel_tag = 3'd0;
      for (int i = ADD_RS - 1; i >= 0; i--) begin
         if (!add_busy_q[i])
            add_sel_tag = 3'(i + 1);
      end
      for (int m = MEM_RS - 1; m >= 0; m--) begin
         if (!mem_busy_q[m])
            mem_sel_tag = 3'(ADD_RS + 1 + m);
      end
      alloc_tag = is_mem ? mem_sel_tag : add_sel_tag;
   end

   // Source renaming: SD reads its store data from RX; LD has no second source
   always_comb begin
      src_k = is_sd ? RX : RZ;
      qj_c  = bypass(rst_q[RY], cdb_valid, cdb_tag);
      qk_c  = is_ld ? 3'd0 : bypass(rst_q[src_k], cdb_valid, cdb_tag);
      rk_c  = is_ld ? 3'd0 : src_k;
   end

   // Next occupancy: CDB release first, then allocation so a new owner wins
   always_comb begin
      add_busy_d = add_busy_q;
      mem_busy_d = mem_busy_q;
      for (int i = 0; i < ADD_RS; i++) begin
         if (cdb_hit && (cdb_tag == 3'(i + 1)))
            add_busy_d[i] = 1'b0;
         if (do_issue && !is_mem && (add_sel_tag == 3'(i + 1)))
            add_busy_d[i] = 1'b1;
      end
      for (int m = 0; m < MEM_RS; m++) begin
         if (cdb_hit && (cdb_tag == 3'(ADD_RS + 1 + m)))
            mem_busy_d[m] = 1'b0;
         if (do_issue && is_mem && (mem_sel_tag == 3'(ADD_RS + 1 + m)))
            mem_busy_d[m] = 1'b1;
      end
   end

   // Next RST: clear entries produced by the broadcast tag, then rename the destination
   always_comb begin
      for (int r = 0; r < 8; r++) begin
         rst_d[r] = rst_q[r];
         if (cdb_hit && (rst_q[r] == cdb_tag))
            rst_d[r] = 3'd0;
         if (writes_dest && (RX == 3'(r)))
            rst_d[r] = alloc_tag;
      end
   end

   // Occupancy and rename state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         add_busy_q <= '0;
         mem_busy_q <= '0;
         for (int r = 0; r < 8; r++)
            rst_q[r] <= 3'd0;
      end else begin
         add_busy_q <= add_busy_d;
         mem_busy_q <= mem_busy_d;
         for (int r = 0; r < 8; r++)
            rst_q[r] <= rst_d[r];
      end
   end

   // Registered issue record; fields hold between issues, valid pulses for one cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         issue_valid <= 1'b0;
         issue_unit  <= 1'b0;
         issue_tag   <= 3'd0;
         issue_op    <= 3'd0;
         issue_qj    <= 3'd0;
         issue_qk    <= 3'd0;
         issue_rj    <= 3'd0;
         issue_rk    <= 3'd0;
         issue_imm   <= 4'd0;
      end else begin
         issue_valid <= do_issue;
         if (do_issue) begin
            issue_unit <= is_mem;
            issue_tag  <= alloc_tag;
            issue_op   <= opcode;
            issue_qj   <= qj_c;
            issue_qk   <= qk_c;
            issue_rj   <= RY;
            issue_rk   <= rk_c;
            issue_imm  <= immediate;
         end
      end
   end

   assign stall    = stall_c;
   assign add_busy = add_busy_q;
   assign mem_busy = mem_busy_q;

`ifdef ISSUE_STATS_EN
   // Saturating counters of issue pulses and stalled cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_issued <= 16'd0;
         stat_stalls <= 16'd0;
      end else begin
         if (do_issue && (stat_issued != 16'hFFFF))
            stat_issued <= stat_issued + 16'd1;
         if (stall_c && (stat_stalls != 16'hFFFF))
            stat_stalls <= stat_stalls + 16'd1;
      end
   end
`else
   assign stat_issued = 16'd0;
   assign stat_stalls = 16'd0;
`endif

endmodule
